// File: rtl/pll_clken_manager.sv
// PLL lock qualification, system reset release and fractional clock-enable strobes.
// Everything runs on the PLL clock; the strobes are derived from per-channel phase accumulators.
module pll_clken_manager #(
    parameter int unsigned N_CH        = 4,
    parameter int unsigned ACC_W       = 24,
    parameter int unsigned LOCK_STABLE = 1024
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   PLL_LOCK,
    input  logic [N_CH*ACC_W-1:0]  INC,
    input  logic [N_CH-1:0]        CH_EN,
    input  logic                   SYNC,
    input  logic                   LOST_CLR,
    output logic                   READY,
    output logic                   SYS_RSTN,
    output logic [N_CH-1:0]        CE,
    output logic                   LOCK_LOST
);

    localparam int unsigned CNT_W = $clog2(LOCK_STABLE);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_STABLE - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK,
        STABLE,
        RUN
    } state_t;

    logic             r_sync1;
    logic             r_lk;
    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_set_lost;
    logic             w_run;
    logic             r_sys_rstn;
    logic             r_lock_lost;
    logic [ACC_W-1:0] r_acc [N_CH];
    logic [ACC_W:0]   w_sum [N_CH];
    logic [N_CH-1:0]  r_ce;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_sync1 <= 1'b0;
            r_lk    <= 1'b0;
        end else begin
            r_sync1 <= PLL_LOCK;
            r_lk    <= r_sync1;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state <= WAIT_LOCK;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_set_lost  = 1'b0;
        case (r_state)
            WAIT_LOCK: begin
                w_cnt_nxt = '0;
                if (r_lk) w_state_nxt = STABLE;
            end
            STABLE: begin
                if (!r_lk) begin
                    w_state_nxt = WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = RUN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            RUN: begin
                w_cnt_nxt = '0;
                if (!r_lk) begin
                    w_state_nxt = WAIT_LOCK;
                    w_set_lost  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = WAIT_LOCK;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign w_run = (r_state == RUN);

    // Set has priority so a loss coinciding with a clear is never missed.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_sys_rstn  <= 1'b0;
            r_lock_lost <= 1'b0;
        end else begin
            r_sys_rstn <= w_run;
            if (w_set_lost)    r_lock_lost <= 1'b1;
            else if (LOST_CLR) r_lock_lost <= 1'b0;
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < N_CH; i++) begin
            w_sum[i] = {1'b0, r_acc[i]} + {1'b0, INC[i*ACC_W +: ACC_W]};
        end
    end

    // Accumulators sit at zero outside RUN so strobes restart phase-aligned after relock.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int unsigned i = 0; i < N_CH; i++) r_acc[i] <= '0;
            r_ce <= '0;
        end else begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                if (!w_run || SYNC) begin
                    r_acc[i] <= '0;
                    r_ce[i]  <= 1'b0;
                end else if (CH_EN[i]) begin
                    r_acc[i] <= w_sum[i][ACC_W-1:0];
                    r_ce[i]  <= w_sum[i][ACC_W];
                end else begin
                    r_ce[i] <= 1'b0;
                end
            end
        end
    end

    assign READY     = w_run;
    assign SYS_RSTN  = r_sys_rstn;
    assign CE        = r_ce;
    assign LOCK_LOST = r_lock_lost;

endmodule

// File: tb/tb_pll_clken_manager.sv
// Self-checking bench for pll_clken_manager: directed steps plus randomized traffic
// compared every cycle against a behavioural reference model.
module tb_pll_clken_manager;

    localparam int N_CH  = 4;
    localparam int ACC_W = 24;
    localparam int LS    = 16;

    logic                  CLK = 1'b0;
    logic                  RESET;
    logic                  PLL_LOCK;
    logic [N_CH*ACC_W-1:0] INC;
    logic [N_CH-1:0]       CH_EN;
    logic                  SYNC;
    logic                  LOST_CLR;
    logic                  READY;
    logic                  SYS_RSTN;
    logic [N_CH-1:0]       CE;
    logic                  LOCK_LOST;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    pll_clken_manager #(
        .N_CH       (N_CH),
        .ACC_W      (ACC_W),
        .LOCK_STABLE(LS)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .PLL_LOCK (PLL_LOCK),
        .INC      (INC),
        .CH_EN    (CH_EN),
        .SYNC     (SYNC),
        .LOST_CLR (LOST_CLR),
        .READY    (READY),
        .SYS_RSTN (SYS_RSTN),
        .CE       (CE),
        .LOCK_LOST(LOCK_LOST)
    );

    // Reference model: READY holds once the sampled lock has been 1 for LS+1
    // consecutive edges, seen through a two-edge synchroniser delay.
    int                m_run;
    int                m_run_d1;
    logic              m_ready;
    logic              m_sysrstn;
    logic              m_lost;
    longint unsigned   m_acc [N_CH];
    logic [N_CH-1:0]   m_ce;
    localparam longint unsigned MOD = 64'd1 << ACC_W;

    always @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            m_run     <= 0;
            m_run_d1  <= 0;
            m_ready   <= 1'b0;
            m_sysrstn <= 1'b0;
            m_lost    <= 1'b0;
            m_ce      <= '0;
            for (int i = 0; i < N_CH; i++) m_acc[i] <= 0;
        end else begin
            m_run     <= PLL_LOCK ? ((m_run < 1000000) ? m_run + 1 : m_run) : 0;
            m_run_d1  <= m_run;
            m_ready   <= (m_run_d1 >= LS + 1);
            m_sysrstn <= m_ready;
            if (m_ready && !(m_run_d1 >= LS + 1)) m_lost <= 1'b1;
            else if (LOST_CLR)                     m_lost <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                if (!m_ready || SYNC) begin
                    m_acc[i] <= 0;
                    m_ce[i]  <= 1'b0;
                end else if (CH_EN[i]) begin
                    m_acc[i] <= (m_acc[i] + 64'(INC[i*ACC_W +: ACC_W])) % MOD;
                    m_ce[i]  <= ((m_acc[i] + 64'(INC[i*ACC_W +: ACC_W])) >= MOD);
                end else begin
                    m_ce[i] <= 1'b0;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        chk("model_ready",   64'(READY),     64'(m_ready));
        chk("model_sysrstn", 64'(SYS_RSTN),  64'(m_sysrstn));
        chk("model_ce",      64'(CE),        64'(m_ce));
        chk("model_lost",    64'(LOCK_LOST), 64'(m_lost));
    endtask

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
        check_model();
    endtask

    task automatic set_inc(input int c, input logic [ACC_W-1:0] v);
        INC[c*ACC_W +: ACC_W] = v;
    endtask

    int cnt;

    initial begin
        RESET    = 1'b0;
        PLL_LOCK = 1'b0;
        SYNC     = 1'b0;
        LOST_CLR = 1'b0;
        CH_EN    = 4'b0111;
        INC      = '0;
        set_inc(0, 24'h400000);
        set_inc(1, 24'h800000);
        set_inc(2, 24'h000000);
        set_inc(3, 24'h123456);

        // Reset values
        repeat (5) @(negedge CLK);
        chk("rst_ready",   64'(READY),     64'd0);
        chk("rst_sysrstn", 64'(SYS_RSTN),  64'd0);
        chk("rst_ce",      64'(CE),        64'd0);
        chk("rst_lost",    64'(LOCK_LOST), 64'd0);
        RESET = 1'b1;
        tick();
        tick();

        // Lock qualification: READY after edge 19, SYS_RSTN after edge 20
        PLL_LOCK = 1'b1;
        for (int e = 1; e <= 19; e++) begin
            tick();
            chk("qual_ready",   64'(READY),    64'(e >= 19));
            chk("qual_sysrstn", 64'(SYS_RSTN), 64'd0);
            chk("qual_ce_idle", 64'(CE),       64'd0);
        end

        // Strobe pattern after READY: CE0 every 4th, CE1 every 2nd
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk("run_sysrstn", 64'(SYS_RSTN), 64'd1);
            chk("run_ce0",     64'(CE[0]),    64'((k % 4) == 0));
            chk("run_ce1",     64'(CE[1]),    64'((k % 2) == 0));
            chk("run_ce23",    64'(CE[3:2]),  64'd0);
        end

        // Misalign phases, then SYNC realigns all channels
        set_inc(0, 24'h300000);
        repeat (5) tick();
        set_inc(0, 24'h400000);
        SYNC = 1'b1;
        tick();
        SYNC = 1'b0;
        chk("sync_ce", 64'(CE), 64'd0);
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk("sync_ce0", 64'(CE[0]), 64'((k % 4) == 0));
            chk("sync_ce1", 64'(CE[1]), 64'((k % 2) == 0));
        end

        // Channel 1 frozen for three cycles
        CH_EN = 4'b0101;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("frz_ce1", 64'(CE[1]), 64'd0);
        end
        CH_EN = 4'b0111;
        repeat (8) tick();

        // Lock drop in RUN
        PLL_LOCK = 1'b0;
        tick();
        chk("drop_ready1", 64'(READY), 64'd1);
        tick();
        chk("drop_ready2", 64'(READY), 64'd1);
        tick();
        chk("drop_ready3",   64'(READY),     64'd0);
        chk("drop_sysrstn3", 64'(SYS_RSTN),  64'd1);
        chk("drop_lost3",    64'(LOCK_LOST), 64'd1);
        tick();
        chk("drop_sysrstn4", 64'(SYS_RSTN),  64'd0);
        chk("drop_ce4",      64'(CE),        64'd0);
        repeat (5) tick();
        chk("lost_sticky", 64'(LOCK_LOST), 64'd1);
        LOST_CLR = 1'b1;
        tick();
        LOST_CLR = 1'b0;
        chk("lost_clr", 64'(LOCK_LOST), 64'd0);

        // Short glitch during qualification restarts the full count
        PLL_LOCK = 1'b1;
        repeat (10) tick();
        PLL_LOCK = 1'b0;
        tick();
        chk("glitch_ready", 64'(READY), 64'd0);
        PLL_LOCK = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            tick();
            chk("requal_ready", 64'(READY), 64'(e >= 19));
        end

        // Loss coinciding with a clear: set wins
        LOST_CLR = 1'b1;
        PLL_LOCK = 1'b0;
        repeat (3) tick();
        chk("setwin_lost", 64'(LOCK_LOST), 64'd1);
        tick();
        chk("setwin_clear", 64'(LOCK_LOST), 64'd0);
        LOST_CLR = 1'b0;

        // Randomized traffic against the model
        PLL_LOCK = 1'b1;
        repeat (20) tick();
        for (int n = 0; n < 3000; n++) begin
            if ((n % 16) == 0) begin
                for (int c = 0; c < N_CH; c++) set_inc(c, ACC_W'($urandom));
                CH_EN = N_CH'($urandom);
            end
            SYNC     = ($urandom_range(0, 31) == 0);
            LOST_CLR = ($urandom_range(0, 63) == 0);
            if (!PLL_LOCK)                          PLL_LOCK = 1'b1;
            else if ($urandom_range(0, 599) == 0)  PLL_LOCK = 1'b0;
            tick();
        end
        SYNC     = 1'b0;
        LOST_CLR = 1'b0;
        PLL_LOCK = 1'b1;
        repeat (20) tick();
        chk("rand_ready_end", 64'(READY), 64'd1);

        // Average rate: INC = 2^20 gives exactly one strobe per 16 cycles
        CH_EN = 4'b0001;
        set_inc(0, 24'h100000);
        SYNC = 1'b1;
        tick();
        SYNC = 1'b0;
        cnt = 0;
        for (int k = 0; k < 4096; k++) begin
            tick();
            if (CE[0]) cnt++;
        end
        chk("rate_2p20", 64'(cnt), 64'd256);

        // 48 kHz increment: 40000 cycles -> 30 strobes, one count tolerance
        set_inc(0, 24'd12583);
        SYNC = 1'b1;
        tick();
        SYNC = 1'b0;
        cnt = 0;
        for (int k = 0; k < 40000; k++) begin
            tick();
            if (CE[0]) cnt++;
        end
        chk("rate_48k", 64'((cnt >= 29) && (cnt <= 31)), 64'd1);

        // Maximum increment strobes every cycle after the first add
        set_inc(0, 24'hFFFFFF);
        SYNC = 1'b1;
        tick();
        SYNC = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            chk("max_inc_ce0", 64'(CE[0]), 64'(k >= 2));
        end

        // Asynchronous reset mid-run
        CH_EN = 4'b0111;
        set_inc(1, 24'h800000);
        repeat (6) tick();
        #2 RESET = 1'b0;
        #1;
        chk("arst_ready",   64'(READY),     64'd0);
        chk("arst_sysrstn", 64'(SYS_RSTN),  64'd0);
        chk("arst_ce",      64'(CE),        64'd0);
        chk("arst_lost",    64'(LOCK_LOST), 64'd0);
        @(negedge CLK);
        RESET = 1'b1;
        repeat (3) tick();
        chk("post_arst_ready", 64'(READY), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
